// File: rtl/axi4_outstanding_tracker.sv
// axi4_outstanding_tracker
//
// Tracks the outstanding transactions of one AXI4 channel pair: AW->B when
// BEAT_CHECK=0, AR->R when BEAT_CHECK=1. Address-phase handshakes are appended
// to an age-ordered table in which index 0 is the oldest entry. Each response
// beat is matched to the oldest entry that carries the same ID. That entry is
// then either retired, or has the beat counted against its burst length. The
// entries above a retired one shift down in the same edge, so the valid
// entries always occupy 0..count-1.
//
// Ports
//   aclk, areset         clock; asynchronous active-high reset
//   push_valid/ready     address-phase transaction offered / table not full
//   push_id/addr/len     ID, start address and burst length (beats = len+1)
//   resp_valid           one response beat observed (no back-pressure)
//   resp_id, resp_last   response ID; last beat of burst (BEAT_CHECK=1 only)
//   count, full, empty   registered occupancy
//   retire_valid/id/addr one-cycle pulse with the retired entry's ID/address
//   err_unexpected_id    pulse: response ID matches no outstanding entry
//   err_order            pulse: in-order mode, response not for the oldest entry
//   err_last             pulse: beat count disagrees with resp_last
module axi4_outstanding_tracker #(
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int DEPTH        = 16,
  parameter int OUT_OF_ORDER = 1,
  parameter int BEAT_CHECK   = 1,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int IW          = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ID_WIDTH-1:0]   push_id,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [LEN_WIDTH-1:0]  push_len,
  input  logic                  resp_valid,
  input  logic [ID_WIDTH-1:0]   resp_id,
  input  logic                  resp_last,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  retire_valid,
  output logic [ID_WIDTH-1:0]   retire_id,
  output logic [ADDR_WIDTH-1:0] retire_addr,
  output logic                  err_unexpected_id,
  output logic                  err_order,
  output logic                  err_last
);

  // Entry table, index 0 = oldest.
  logic [ID_WIDTH-1:0]   id_q    [DEPTH];
  logic [ID_WIDTH-1:0]   id_d    [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d  [DEPTH];
  logic [LEN_WIDTH-1:0]  len_q   [DEPTH];
  logic [LEN_WIDTH-1:0]  len_d   [DEPTH];
  logic [LEN_WIDTH-1:0]  beats_q [DEPTH];
  logic [LEN_WIDTH-1:0]  beats_d [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;

  logic                  retire_valid_q;
  logic [ID_WIDTH-1:0]   retire_id_q;
  logic [ADDR_WIDTH-1:0] retire_addr_q;
  logic                  err_unexp_q, err_order_q, err_last_q;

  // Lookup results
  logic                  hit;
  logic [IW-1:0]         m_idx;
  logic [ID_WIDTH-1:0]   m_id;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [LEN_WIDTH-1:0]  m_len;
  logic [LEN_WIDTH-1:0]  m_beats;

  // Per-cycle decisions
  logic          resp_hit;
  logic          unexp;
  logic          order_err;
  logic          retire;
  logic          beat_inc;
  logic          last_err;
  logic          push_acc;
  logic [CW-1:0] wr_idx;

  // Priority encoder. Only entries valid at the start of the cycle take part
  // in the search. Scanning from the top down lets the lowest matching index
  // win, which is the oldest entry with this ID.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves a signal unassigned would infer a latch.
    hit   = 1'b0;
    m_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < count_q) && (id_q[i] == resp_id)) begin
        hit   = 1'b1;
        m_idx = IW'(i);
      end
    end
  end

  assign m_id    = id_q[m_idx];
  assign m_addr  = addr_q[m_idx];
  assign m_len   = len_q[m_idx];
  assign m_beats = beats_q[m_idx];

  // Response classification. The beats field counts non-last beats, so a
  // burst is complete when beats == len and the next beat is marked last.
  always_comb begin
    resp_hit  = resp_valid && hit;
    unexp     = resp_valid && !hit;
    order_err = resp_hit && (OUT_OF_ORDER == 0) && (m_idx != '0);
    retire    = 1'b0;
    beat_inc  = 1'b0;
    last_err  = 1'b0;
    if (resp_hit) begin
      if (BEAT_CHECK == 0) begin
        retire = 1'b1;
      end else if (resp_last) begin
        retire   = 1'b1;
        last_err = (m_beats != m_len);
      end else if (m_beats == m_len) begin
        // Another non-last beat would exceed the burst: flag it and keep the
        // entry outstanding.
        last_err = 1'b1;
      end else begin
        beat_inc = 1'b1;
      end
    end
  end

  // push_ready comes only from the registered full flag. It ignores any
  // retire in the same cycle, so the ready path stays free of the lookup logic.
  assign push_acc = push_valid && !full_q;
  // The pushed entry goes into the first free slot after compaction.
  assign wr_idx   = count_q - CW'(retire);

  // Table next state: compact above m, count the beat, then append.
  always_comb begin
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beats_d = beats_q;

    if (retire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= m_idx) begin
          id_d[i]    = id_q[i+1];
          addr_d[i]  = addr_q[i+1];
          len_d[i]   = len_q[i+1];
          beats_d[i] = beats_q[i+1];
        end
      end
    end

    // A beat is never counted in the same cycle as a retire, so slot m
    // has not been moved.
    if (beat_inc) begin
      beats_d[m_idx] = m_beats + LEN_WIDTH'(1);
    end

    if (push_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          id_d[i]    = push_id;
          addr_d[i]  = push_addr;
          len_d[i]   = push_len;
          beats_d[i] = '0;
        end
      end
    end

    count_d = count_q + CW'(push_acc) - CW'(retire);
  end

  // Control state and registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      beats_q        <= '{default: '0};
      retire_valid_q <= 1'b0;
      retire_id_q    <= '0;
      retire_addr_q  <= '0;
      err_unexp_q    <= 1'b0;
      err_order_q    <= 1'b0;
      err_last_q     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so each register
      // samples values from before the edge regardless of statement order.
      count_q        <= count_d;
      full_q         <= (count_d == CW'(DEPTH));
      empty_q        <= (count_d == '0);
      beats_q        <= beats_d;
      retire_valid_q <= retire;
      retire_id_q    <= retire ? m_id : '0;
      retire_addr_q  <= retire ? m_addr : '0;
      err_unexp_q    <= unexp;
      err_order_q    <= order_err;
      err_last_q     <= last_err;
    end
  end

  // NOTE: the id/addr/len payload has no reset. Validity comes only from
  // count_q, and every slot is written before it is ever read as valid.
  // Without a reset these fields can be mapped onto plain storage.
  always_ff @(posedge aclk) begin
    id_q   <= id_d;
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  assign push_ready        = !full_q;
  assign count             = count_q;
  assign full              = full_q;
  assign empty             = empty_q;
  assign retire_valid      = retire_valid_q;
  assign retire_id         = retire_id_q;
  assign retire_addr       = retire_addr_q;
  assign err_unexpected_id = err_unexp_q;
  assign err_order         = err_order_q;
  assign err_last          = err_last_q;

endmodule

// File: tb/tb_axi4_outstanding_tracker.sv
// Testbench for axi4_outstanding_tracker. Three instances are driven with the
// same stimulus:
//   cfg0: out-of-order, beat check (AR->R)
//   cfg1: in-order,     beat check
//   cfg2: out-of-order, no beat check (AW->B)
// A queue-based reference model for each configuration predicts every output
// after every clock edge. Directed scenarios come first, then random traffic.
module tb_axi4_outstanding_tracker;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int NCFG   = 3;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    int                len;
    int                beats;   // non-last beats seen so far
  } ent_t;

  logic              aclk = 1'b0;
  logic              areset = 1'b0;
  logic              push_valid = 1'b0;
  logic [ID_W-1:0]   push_id = '0;
  logic [ADDR_W-1:0] push_addr = '0;
  logic [LEN_W-1:0]  push_len = '0;
  logic              resp_valid = 1'b0;
  logic [ID_W-1:0]   resp_id = '0;
  logic              resp_last = 1'b0;

  logic              d_ready [NCFG];
  logic [CW-1:0]     d_count [NCFG];
  logic              d_full  [NCFG];
  logic              d_empty [NCFG];
  logic              d_rv    [NCFG];
  logic [ID_W-1:0]   d_rid   [NCFG];
  logic [ADDR_W-1:0] d_raddr [NCFG];
  logic              d_eu    [NCFG];
  logic              d_eo    [NCFG];
  logic              d_el    [NCFG];

  axi4_outstanding_tracker #(.OUT_OF_ORDER(1), .BEAT_CHECK(1)) u_ooo (
    .aclk(aclk), .areset(areset),
    .push_valid(push_valid), .push_ready(d_ready[0]),
    .push_id(push_id), .push_addr(push_addr), .push_len(push_len),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_last(resp_last),
    .count(d_count[0]), .full(d_full[0]), .empty(d_empty[0]),
    .retire_valid(d_rv[0]), .retire_id(d_rid[0]), .retire_addr(d_raddr[0]),
    .err_unexpected_id(d_eu[0]), .err_order(d_eo[0]), .err_last(d_el[0])
  );

  axi4_outstanding_tracker #(.OUT_OF_ORDER(0), .BEAT_CHECK(1)) u_ino (
    .aclk(aclk), .areset(areset),
    .push_valid(push_valid), .push_ready(d_ready[1]),
    .push_id(push_id), .push_addr(push_addr), .push_len(push_len),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_last(resp_last),
    .count(d_count[1]), .full(d_full[1]), .empty(d_empty[1]),
    .retire_valid(d_rv[1]), .retire_id(d_rid[1]), .retire_addr(d_raddr[1]),
    .err_unexpected_id(d_eu[1]), .err_order(d_eo[1]), .err_last(d_el[1])
  );

  axi4_outstanding_tracker #(.OUT_OF_ORDER(1), .BEAT_CHECK(0)) u_bc0 (
    .aclk(aclk), .areset(areset),
    .push_valid(push_valid), .push_ready(d_ready[2]),
    .push_id(push_id), .push_addr(push_addr), .push_len(push_len),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_last(resp_last),
    .count(d_count[2]), .full(d_full[2]), .empty(d_empty[2]),
    .retire_valid(d_rv[2]), .retire_id(d_rid[2]), .retire_addr(d_raddr[2]),
    .err_unexpected_id(d_eu[2]), .err_order(d_eo[2]), .err_last(d_el[2])
  );

  always #5 aclk = ~aclk;

  // Reference model state and expected pulse outputs
  ent_t              mq [NCFG][$];
  logic              e_rv    [NCFG];
  logic [ID_W-1:0]   e_rid   [NCFG];
  logic [ADDR_W-1:0] e_raddr [NCFG];
  logic              e_eu    [NCFG];
  logic              e_eo    [NCFG];
  logic              e_el    [NCFG];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge, using the inputs currently driven.
  task automatic model_step(input int c);
    bit   ooo;
    bit   bc;
    bit   do_ret;
    int   m;
    ent_t e;
    ooo    = (c != 1);
    bc     = (c != 2);
    do_ret = 1'b0;
    m      = -1;
    e_rv[c] = 1'b0; e_rid[c] = '0; e_raddr[c] = '0;
    e_eu[c] = 1'b0; e_eo[c] = 1'b0; e_el[c] = 1'b0;
    if (resp_valid) begin
      for (int k = 0; k < mq[c].size(); k++) begin
        if (mq[c][k].id == resp_id) begin
          m = k;
          break;
        end
      end
      if (m < 0) begin
        e_eu[c] = 1'b1;
      end else begin
        if (!ooo && m != 0) e_eo[c] = 1'b1;
        if (!bc) begin
          do_ret = 1'b1;
        end else if (resp_last) begin
          do_ret  = 1'b1;
          e_el[c] = (mq[c][m].beats != mq[c][m].len);
        end else if (mq[c][m].beats == mq[c][m].len) begin
          e_el[c] = 1'b1;
        end else begin
          mq[c][m].beats = mq[c][m].beats + 1;
        end
        if (do_ret) begin
          e_rv[c]    = 1'b1;
          e_rid[c]   = mq[c][m].id;
          e_raddr[c] = mq[c][m].addr;
          mq[c].delete(m);
        end
      end
    end
    // Full is judged on the occupancy before this edge; a same-cycle retire
    // does not make room.
    if (push_valid && (mq[c].size() + (do_ret ? 1 : 0) < DEPTH)) begin
      e.id    = push_id;
      e.addr  = push_addr;
      e.len   = int'(push_len);
      e.beats = 0;
      mq[c].push_back(e);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d count", c), 64'(d_count[c]), 64'(mq[c].size()));
      check($sformatf("cfg%0d full", c), 64'(d_full[c]), 64'(mq[c].size() == DEPTH));
      check($sformatf("cfg%0d empty", c), 64'(d_empty[c]), 64'(mq[c].size() == 0));
      check($sformatf("cfg%0d push_ready", c), 64'(d_ready[c]), 64'(mq[c].size() < DEPTH));
      check($sformatf("cfg%0d retire_valid", c), 64'(d_rv[c]), 64'(e_rv[c]));
      check($sformatf("cfg%0d err_unexpected_id", c), 64'(d_eu[c]), 64'(e_eu[c]));
      check($sformatf("cfg%0d err_order", c), 64'(d_eo[c]), 64'(e_eo[c]));
      check($sformatf("cfg%0d err_last", c), 64'(d_el[c]), 64'(e_el[c]));
      if (e_rv[c]) begin
        check($sformatf("cfg%0d retire_id", c), 64'(d_rid[c]), 64'(e_rid[c]));
        check($sformatf("cfg%0d retire_addr", c), 64'(d_raddr[c]), 64'(e_raddr[c]));
      end
    end
  endtask

  // One clock: drive the inputs, step the models, then sample 1 ns after the edge.
  task automatic step(input bit pv, input logic [ID_W-1:0] pid, input logic [ADDR_W-1:0] pa,
                      input logic [LEN_W-1:0] pl, input bit rv, input logic [ID_W-1:0] rid,
                      input bit rl);
    push_valid = pv; push_id = pid; push_addr = pa; push_len = pl;
    resp_valid = rv; resp_id = rid; resp_last = rl;
    for (int c = 0; c < NCFG; c++) model_step(c);
    @(posedge aclk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [ID_W-1:0] pid, input logic [ADDR_W-1:0] pa, input logic [LEN_W-1:0] pl);
    step(1'b1, pid, pa, pl, 1'b0, '0, 1'b0);
  endtask

  task automatic resp(input logic [ID_W-1:0] rid, input bit rl);
    step(1'b0, '0, '0, '0, 1'b1, rid, rl);
  endtask

  // Raises reset away from any clock edge and checks the outputs
  // before the next edge arrives.
  task automatic assert_reset();
    #2;
    areset = 1'b1;
    push_valid = 1'b0;
    resp_valid = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      mq[c].delete();
      e_rv[c] = 1'b0; e_rid[c] = '0; e_raddr[c] = '0;
      e_eu[c] = 1'b0; e_eo[c] = 1'b0; e_el[c] = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic release_reset();
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  logic [ID_W-1:0] r_rid;
  int              r_idx;
  bit              r_pv, r_rv, r_rl;

  initial begin
    assert_reset();
    release_reset();

    // Plan 1: four R beats retire a len=3 burst
    push(4'd3, 32'h100, 8'd3);
    resp(4'd3, 1'b0);
    resp(4'd3, 1'b0);
    resp(4'd3, 1'b0);
    check("p1 count before last", 64'(d_count[0]), 64'd1);
    check("p1 no early retire", 64'(d_rv[0]), 64'd0);
    resp(4'd3, 1'b1);
    check("p1 retire_valid", 64'(d_rv[0]), 64'd1);
    check("p1 retire_id", 64'(d_rid[0]), 64'd3);
    check("p1 retire_addr", 64'(d_raddr[0]), 64'h100);
    check("p1 count", 64'(d_count[0]), 64'd0);
    check("p1 err_last", 64'(d_el[0]), 64'd0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    check("p1 pulse one cycle", 64'(d_rv[0]), 64'd0);

    // Plan 2: in-order violation is flagged, but the entry still retires
    push(4'd1, 32'h1000, 8'd0);
    push(4'd2, 32'h2000, 8'd0);
    resp(4'd2, 1'b1);
    check("p2 err_order inorder", 64'(d_eo[1]), 64'd1);
    check("p2 err_order ooo", 64'(d_eo[0]), 64'd0);
    check("p2 retire_id", 64'(d_rid[1]), 64'd2);
    check("p2 count", 64'(d_count[1]), 64'd1);
    resp(4'd1, 1'b1);
    check("p2 clean retire", 64'(d_eo[1]), 64'd0);
    check("p2 empty", 64'(d_empty[1]), 64'd1);

    // Plan 3: fill the table; a push while full is refused even with a same-cycle retire
    for (int i = 0; i < DEPTH; i++) push(ID_W'(i), ADDR_W'(i * 64), 8'd0);
    check("p3 full", 64'(d_full[0]), 64'd1);
    check("p3 push_ready", 64'(d_ready[0]), 64'd0);
    step(1'b1, 4'd9, 32'hDEAD, 8'd0, 1'b1, 4'd0, 1'b1);
    check("p3 count after refused push", 64'(d_count[0]), 64'd15);
    check("p3 retire_addr", 64'(d_raddr[1]), 64'h0);
    for (int i = 1; i < DEPTH; i++) resp(ID_W'(i), 1'b1);
    check("p3 drained", 64'(d_empty[1]), 64'd1);

    // Plan 4: unexpected ID; early last beat
    resp(4'd7, 1'b1);
    check("p4 err_unexpected_id", 64'(d_eu[0]), 64'd1);
    check("p4 count unchanged", 64'(d_count[0]), 64'd0);
    push(4'd5, 32'h500, 8'd2);
    resp(4'd5, 1'b0);
    resp(4'd5, 1'b1);
    check("p4 err_last", 64'(d_el[0]), 64'd1);
    check("p4 retired", 64'(d_rv[0]), 64'd1);

    // Beat counter saturates at len: the extra non-last beat is flagged and not retired
    push(4'd6, 32'h600, 8'd1);
    resp(4'd6, 1'b0);
    resp(4'd6, 1'b0);
    check("sat err_last", 64'(d_el[0]), 64'd1);
    check("sat not retired", 64'(d_count[0]), 64'd1);
    resp(4'd6, 1'b1);
    check("sat clean last", 64'(d_el[0]), 64'd0);

    // Longest legal burst: len=255, 256 beats
    push(4'd9, 32'hABC, 8'd255);
    for (int i = 0; i < 255; i++) resp(4'd9, 1'b0);
    resp(4'd9, 1'b1);
    check("len255 retired", 64'(d_rv[0]), 64'd1);
    check("len255 err_last", 64'(d_el[0]), 64'd0);

    // Plan 5: same-ID B responses retire in issue order; reset discards pending entries
    push(4'd4, 32'h10, 8'd0);
    push(4'd4, 32'h20, 8'd0);
    resp(4'd4, 1'b1);
    check("p5 first addr", 64'(d_raddr[2]), 64'h10);
    resp(4'd4, 1'b1);
    check("p5 second addr", 64'(d_raddr[2]), 64'h20);
    push(4'd1, 32'h1, 8'd0);
    push(4'd2, 32'h2, 8'd0);
    push(4'd3, 32'h3, 8'd0);
    assert_reset();
    check("p5 reset count", 64'(d_count[2]), 64'd0);
    check("p5 reset empty", 64'(d_empty[2]), 64'd1);
    release_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r_pv = ($urandom_range(0, 99) < 45);
      r_rv = ($urandom_range(0, 99) < 55);
      r_rl = ($urandom_range(0, 2) == 0);
      if (mq[0].size() > 0 && $urandom_range(0, 9) < 8) begin
        r_idx = int'($urandom_range(0, mq[0].size() - 1));
        r_rid = mq[0][r_idx].id;
      end else begin
        r_rid = ID_W'($urandom_range(0, 15));
      end
      step(r_pv, ID_W'($urandom_range(0, 7)), $urandom(), LEN_W'($urandom_range(0, 3)),
           r_rv, r_rid, r_rl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
